// File: rtl/vx_vector_uop_sequencer_if.sv
// Handshake bundle between vector dispatch, the uop sequencer and the ALU dispatch path.
// The sequencer uses the slave view; the dispatch/ALU environment uses the master view.
interface vx_vector_uop_sequencer_if #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int VLEN        = 256,
  parameter int TAG_WIDTH   = 8
);
  localparam int VLMAX     = VLEN / XLEN;
  localparam int VL_W      = $clog2(VLMAX + 1);
  localparam int MAX_BEATS = (VLMAX + NUM_THREADS - 1) / NUM_THREADS;
  localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic                        req_valid;
  logic                        req_ready;
  logic [VL_W-1:0]             req_vl;
  logic [TAG_WIDTH-1:0]        req_tag;
  logic [VLEN-1:0]             req_vs1;
  logic [VLEN-1:0]             req_vs2;

  logic                        uop_valid;
  logic                        uop_ready;
  logic [NUM_THREADS-1:0]      uop_tmask;
  logic [NUM_THREADS*XLEN-1:0] uop_rs1;
  logic [NUM_THREADS*XLEN-1:0] uop_rs2;
  logic [BEAT_W-1:0]           uop_beat;
  logic                        uop_last;
  logic [TAG_WIDTH-1:0]        uop_tag;

  modport master (
    output req_valid, req_vl, req_tag, req_vs1, req_vs2, uop_ready,
    input  req_ready, uop_valid, uop_tmask, uop_rs1, uop_rs2, uop_beat, uop_last, uop_tag
  );

  modport slave (
    input  req_valid, req_vl, req_tag, req_vs1, req_vs2, uop_ready,
    output req_ready, uop_valid, uop_tmask, uop_rs1, uop_rs2, uop_beat, uop_last, uop_tag
  );
endinterface

// File: rtl/vx_vector_uop_sequencer.sv
// Splits one vector instruction (SEW = XLEN) into NUM_THREADS-wide beats for the scalar ALU
// dispatch path, with lane masking, operand slicing and pipelined accept on the last beat.
module vx_vector_uop_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int VLEN        = 256,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  output logic                      busy,
  vx_vector_uop_sequencer_if.slave  bus
);
  localparam int VLMAX     = VLEN / XLEN;
  localparam int VL_W      = $clog2(VLMAX + 1);
  localparam int MAX_BEATS = (VLMAX + NUM_THREADS - 1) / NUM_THREADS;
  localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int NSLOT     = 1 << BEAT_W;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [BEAT_W-1:0]           r_beat_cnt;
  logic [BEAT_W-1:0]           w_beat_nxt;
  logic [BEAT_W-1:0]           r_last_beat;
  logic [VL_W-1:0]             r_vl;
  logic [TAG_WIDTH-1:0]        r_tag;
  logic [VLEN-1:0]             r_vs1;
  logic [VLEN-1:0]             r_vs2;

  logic [VL_W-1:0]             w_vl_eff;
  logic [BEAT_W-1:0]           w_last_beat;
  logic                        w_issue;
  logic                        w_last;
  logic                        w_req_fire;
  logic                        w_uop_fire;
  logic                        w_load;

  logic [NUM_THREADS-1:0]      w_mask_slot [NSLOT];
  logic [NUM_THREADS*XLEN-1:0] w_rs1_slot  [NSLOT];
  logic [NUM_THREADS*XLEN-1:0] w_rs2_slot  [NSLOT];

  assign w_vl_eff    = (bus.req_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : bus.req_vl;
  assign w_last_beat = (w_vl_eff == '0) ? '0
                     : BEAT_W'((int'(w_vl_eff) - 1) / NUM_THREADS);

  assign w_issue    = (r_state == ISSUE);
  assign w_last     = w_issue && (r_beat_cnt == r_last_beat);
  assign w_uop_fire = w_issue && bus.uop_ready;

  // Accept in ISSUE only when the last beat leaves this cycle, so the next instruction
  // overlaps its predecessor's final beat without a bubble.
  assign bus.req_ready = !flush && (!w_issue || (bus.uop_ready && w_last));
  assign w_req_fire    = bus.req_valid && bus.req_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_fire && (w_vl_eff != '0)) begin
          w_load      = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          w_beat_nxt  = '0;
          w_state_nxt = IDLE;
        end else if (w_uop_fire) begin
          if (!w_last) begin
            w_beat_nxt = r_beat_cnt + BEAT_W'(1);
          end else if (w_req_fire && (w_vl_eff != '0)) begin
            w_load     = 1'b1;
            w_beat_nxt = '0;
          end else begin
            w_beat_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_beat_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_last_beat <= '0;
      r_vl        <= '0;
      r_tag       <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_load) begin
        r_last_beat <= w_last_beat;
        r_vl        <= w_vl_eff;
        r_tag       <= bus.req_tag;
        r_vs1       <= bus.req_vs1;
        r_vs2       <= bus.req_vs2;
      end
    end
  end

  // Every (beat, lane) pair maps to a fixed element; slots past VLMAX are tied off so no
  // slice ever reaches outside the source vectors.
  for (genvar b = 0; b < NSLOT; b++) begin : g_slot
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
      localparam int E = b * NUM_THREADS + t;
      if (E < VLMAX) begin : g_elem
        logic w_act;
        assign w_act = (VL_W'(E) < r_vl);
        assign w_mask_slot[b][t]              = w_act;
        assign w_rs1_slot[b][t*XLEN +: XLEN]  = w_act ? r_vs1[E*XLEN +: XLEN] : '0;
        assign w_rs2_slot[b][t*XLEN +: XLEN]  = w_act ? r_vs2[E*XLEN +: XLEN] : '0;
      end else begin : g_pad
        assign w_mask_slot[b][t]              = 1'b0;
        assign w_rs1_slot[b][t*XLEN +: XLEN]  = '0;
        assign w_rs2_slot[b][t*XLEN +: XLEN]  = '0;
      end
    end
  end

  assign bus.uop_valid = w_issue;
  assign bus.uop_tmask = w_issue ? w_mask_slot[r_beat_cnt] : '0;
  assign bus.uop_rs1   = w_issue ? w_rs1_slot[r_beat_cnt]  : '0;
  assign bus.uop_rs2   = w_issue ? w_rs2_slot[r_beat_cnt]  : '0;
  assign bus.uop_beat  = w_issue ? r_beat_cnt : '0;
  assign bus.uop_last  = w_last;
  assign bus.uop_tag   = w_issue ? r_tag : '0;
  assign busy          = w_issue;

endmodule

// File: tb/tb_vx_vector_uop_sequencer.sv
// Bench for vx_vector_uop_sequencer: a table of instructions plus hand-written stall,
// back-to-back, flush and reset sequences, with a beat scoreboard fed from accepted requests.
module tb_vx_vector_uop_sequencer;
  localparam int NT    = 4;
  localparam int XL    = 32;
  localparam int VLEN  = 256;
  localparam int TAGW  = 8;
  localparam int VLW   = 4;
  localparam int VLMAX = VLEN / XL;

  typedef struct {
    logic [NT-1:0]    tmask;
    logic [NT*XL-1:0] rs1;
    logic [NT*XL-1:0] rs2;
    logic             beat;
    logic             last;
    logic [TAGW-1:0]  tag;
  } beat_t;

  typedef struct {
    int              vl;
    logic [TAGW-1:0] tag;
    int              expBeats;
    logic [NT-1:0]   expFirst;
    logic [NT-1:0]   expLast;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;

  int nVectors     = 0;
  int nMiscompares = 0;
  int fireCount    = 0;
  logic [NT-1:0] firstMask;
  logic [NT-1:0] lastMask;

  beat_t expQ[$];
  beat_t expBeat;
  logic holdValid;
  logic [2*NT*XL-1:0] holdRs;
  logic [NT+TAGW+1:0] holdCtl;

  vx_vector_uop_sequencer_if #(.NUM_THREADS(NT), .XLEN(XL), .VLEN(VLEN), .TAG_WIDTH(TAGW)) bus ();

  vx_vector_uop_sequencer #(.NUM_THREADS(NT), .XLEN(XL), .VLEN(VLEN), .TAG_WIDTH(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: expand one accepted instruction into its expected beats.
  function automatic void pushExpected(input int vl, input logic [TAGW-1:0] tag,
                                       input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2);
    int vle;
    int nb;
    int e;
    beat_t bt;
    vle = (vl > VLMAX) ? VLMAX : vl;
    nb  = (vle + NT - 1) / NT;
    for (int b = 0; b < nb; b++) begin
      bt.tmask = '0;
      bt.rs1   = '0;
      bt.rs2   = '0;
      for (int t = 0; t < NT; t++) begin
        e = b * NT + t;
        if (e < vle) begin
          bt.tmask[t]         = 1'b1;
          bt.rs1[t*XL +: XL]  = v1[e*XL +: XL];
          bt.rs2[t*XL +: XL]  = v2[e*XL +: XL];
        end
      end
      bt.beat = b[0];
      bt.last = (b == nb - 1);
      bt.tag  = tag;
      expQ.push_back(bt);
    end
  endfunction

  function automatic logic [VLEN-1:0] seqVec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLMAX; i++) v[i*XL +: XL] = 32'h100 + 32'(i);
    return v;
  endfunction

  function automatic logic [VLEN-1:0] randVec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLMAX; i++) v[i*XL +: XL] = $urandom();
    return v;
  endfunction

  // Monitor: pops and compares each fired beat, checks stall stability, queues new requests.
  always @(negedge clk) begin
    if (!reset) begin
      expQ.delete();
      holdValid = 1'b0;
    end else begin
      if (bus.uop_valid && holdValid) begin
        checkOutput("hold_operands", {bus.uop_rs1, bus.uop_rs2}, holdRs);
        checkOutput("hold_control", {bus.uop_tmask, bus.uop_beat, bus.uop_last, bus.uop_tag}, holdCtl);
      end
      holdValid = bus.uop_valid && !bus.uop_ready;
      holdRs    = {bus.uop_rs1, bus.uop_rs2};
      holdCtl   = {bus.uop_tmask, bus.uop_beat, bus.uop_last, bus.uop_tag};
      if (bus.uop_valid && bus.uop_ready) begin
        fireCount++;
        if (bus.uop_beat == 1'b0) firstMask = bus.uop_tmask;
        if (bus.uop_last) lastMask = bus.uop_tmask;
        if (expQ.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL unexpected_beat: got beat %0d tag 0x%0h, required no beat", bus.uop_beat, bus.uop_tag);
        end else begin
          expBeat = expQ.pop_front();
          checkOutput("beat_tmask", bus.uop_tmask, expBeat.tmask);
          checkOutput("beat_rs1", bus.uop_rs1, expBeat.rs1);
          checkOutput("beat_rs2", bus.uop_rs2, expBeat.rs2);
          checkOutput("beat_index", bus.uop_beat, expBeat.beat);
          checkOutput("beat_last", bus.uop_last, expBeat.last);
          checkOutput("beat_tag", bus.uop_tag, expBeat.tag);
        end
      end
      if (flush) expQ.delete();
      if (bus.req_valid && bus.req_ready)
        pushExpected(int'(bus.req_vl), bus.req_tag, bus.req_vs1, bus.req_vs2);
    end
  end

  // Called shortly after a rising edge; returns shortly after the edge that accepted the request.
  task automatic applyStimulus(input int vl, input logic [TAGW-1:0] tag,
                               input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2);
    logic ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_vl    = VLW'(vl);
    bus.req_tag   = tag;
    bus.req_vs1   = v1;
    bus.req_vs2   = v2;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    if (!ok) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL req_timeout: got req_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle(output int busyCycles);
    busyCycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      busyCycles++;
    end
  endtask

  vec_t vecs[9];
  int   startFires;
  int   busyCycles;

  initial begin
    vecs[0] = '{6,  8'h11, 2, 4'b1111, 4'b0011};
    vecs[1] = '{8,  8'h12, 2, 4'b1111, 4'b1111};
    vecs[2] = '{1,  8'h13, 1, 4'b0001, 4'b0001};
    vecs[3] = '{3,  8'h14, 1, 4'b0111, 4'b0111};
    vecs[4] = '{4,  8'h15, 1, 4'b1111, 4'b1111};
    vecs[5] = '{5,  8'h16, 2, 4'b1111, 4'b0001};
    vecs[6] = '{0,  8'h17, 0, 4'b0000, 4'b0000};
    vecs[7] = '{15, 8'h18, 2, 4'b1111, 4'b1111};
    vecs[8] = '{7,  8'h19, 2, 4'b1111, 4'b0111};

    reset         = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vl    = '0;
    bus.req_tag   = '0;
    bus.req_vs1   = '0;
    bus.req_vs2   = '0;
    bus.uop_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_uop_valid", bus.uop_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_req_ready", bus.req_ready, 1'b1);
    checkOutput("reset_payload", {bus.uop_tmask, bus.uop_beat, bus.uop_last, bus.uop_tag}, '0);
    checkOutput("reset_operands", {bus.uop_rs1, bus.uop_rs2}, '0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      firstMask  = '0;
      lastMask   = '0;
      startFires = fireCount;
      applyStimulus(vecs[i].vl, vecs[i].tag, seqVec(), randVec());
      waitIdle(busyCycles);
      checkOutput("table_busy_cycles", busyCycles, vecs[i].expBeats);
      checkOutput("table_fires", fireCount - startFires, vecs[i].expBeats);
      if (vecs[i].expBeats > 0) begin
        checkOutput("table_first_mask", firstMask, vecs[i].expFirst);
        checkOutput("table_last_mask", lastMask, vecs[i].expLast);
      end
    end

    // Stall on beat 0 for three cycles, then release.
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b0;
    startFires    = fireCount;
    applyStimulus(8, 8'h33, seqVec(), randVec());
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_valid", bus.uop_valid, 1'b1);
      checkOutput("stall_beat", bus.uop_beat, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_beat1_index", bus.uop_beat, 1'b1);
    checkOutput("stall_beat1_last", bus.uop_last, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_idle", busy, 1'b0);
    checkOutput("stall_fires", fireCount - startFires, 2);

    // Back-to-back: B accepted on A's last beat.
    @(posedge clk);
    #1;
    startFires    = fireCount;
    bus.req_valid = 1'b1;
    bus.req_vl    = VLW'(4);
    bus.req_tag   = 8'hA1;
    bus.req_vs1   = seqVec();
    bus.req_vs2   = randVec();
    @(negedge clk);
    checkOutput("b2b_a_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_vl  = VLW'(3);
    bus.req_tag = 8'hB2;
    bus.req_vs2 = randVec();
    @(negedge clk);
    checkOutput("b2b_b_ready", bus.req_ready, 1'b1);
    checkOutput("b2b_a_last", bus.uop_last, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_b_busy", busy, 1'b1);
    checkOutput("b2b_b_tmask", bus.uop_tmask, 4'b0111);
    checkOutput("b2b_b_tag", bus.uop_tag, 8'hB2);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("b2b_idle", busy, 1'b0);
    checkOutput("b2b_fires", fireCount - startFires, 2);

    // Flush while beat 0 is stalled.
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b0;
    startFires    = fireCount;
    applyStimulus(8, 8'h44, seqVec(), randVec());
    @(negedge clk);
    checkOutput("flush_pre_valid", bus.uop_valid, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_req_ready", bus.req_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", busy, 1'b0);
    checkOutput("flush_uop_valid", bus.uop_valid, 1'b0);
    checkOutput("flush_next_ready", bus.req_ready, 1'b1);
    checkOutput("flush_no_fire", fireCount - startFires, 0);
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b1;
    startFires    = fireCount;
    applyStimulus(5, 8'h45, seqVec(), randVec());
    waitIdle(busyCycles);
    checkOutput("flush_after_fires", fireCount - startFires, 2);

    // Asynchronous reset in the middle of an instruction.
    @(posedge clk);
    #1;
    bus.uop_ready = 1'b0;
    applyStimulus(8, 8'h55, seqVec(), randVec());
    @(negedge clk);
    checkOutput("rst_pre_valid", bus.uop_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_uop_valid", bus.uop_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_payload", {bus.uop_tmask, bus.uop_beat, bus.uop_last, bus.uop_tag}, '0);
    checkOutput("rst_operands", {bus.uop_rs1, bus.uop_rs2}, '0);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.uop_ready = 1'b1;
    startFires    = fireCount;
    applyStimulus(1, 8'h66, seqVec(), randVec());
    @(negedge clk);
    checkOutput("rst_after_valid", bus.uop_valid, 1'b1);
    checkOutput("rst_after_tmask", bus.uop_tmask, 4'b0001);
    checkOutput("rst_after_last", bus.uop_last, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_after_idle", busy, 1'b0);
    checkOutput("rst_after_fires", fireCount - startFires, 1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
